// File: rtl/sprite_pkg.sv
// Shared sprite constants and colour types for the pacman and ghost renderers.
// Holds the sprite box size, screen extents and the fixed palette colours.
// Types and constants only; no logic lives here.
package sprite_pkg;

  typedef logic [23:0] rgb_t;

  localparam int SPR_W     = 20;
  localparam int SPR_H     = 20;
  localparam int SPR_WORDS = SPR_W * SPR_H;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  localparam rgb_t TRANSPARENT = 24'h000000;
  localparam rgb_t FRIGHT_RGB  = 24'h2121DE;
  localparam rgb_t FLASH_RGB   = 24'hFFFFFF;

endpackage

// File: rtl/ghost_sprite_renderer_if.sv
// Pixel-scan bundle between the VGA timing side and a sprite renderer.
// master: drives scan position, visibility and frame pulse; samples results.
// slave:  the renderer; returns valid/hit/colour three cycles after each pixel.
interface ghost_sprite_renderer_if;
  import sprite_pkg::*;

  logic       frame_start;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_valid;
  logic       out_valid;
  logic       ghost_hit;
  rgb_t       ghost_rgb;

  modport master (
    output frame_start, DrawX, DrawY, pix_valid,
    input  out_valid, ghost_hit, ghost_rgb
  );

  modport slave (
    input  frame_start, DrawX, DrawY, pix_valid,
    output out_valid, ghost_hit, ghost_rgb
  );

endinterface

// File: rtl/sprite_box_addr.sv
// Combinational box test and sprite RAM address for one scan position.
// Ports: draw_x/draw_y scan position, org_x/org_y sprite top-left, en/pix_valid
// qualifiers; in_box flag and row-major addr (0 when outside the box).
module sprite_box_addr
  import sprite_pkg::*;
(
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  input  logic [9:0] org_x,
  input  logic [9:0] org_y,
  input  logic       en,
  input  logic       pix_valid,
  output logic       in_box,
  output logic [8:0] addr
);

  // One extra bit so org+size never wraps for sprites near the right/bottom edge.
  logic [10:0] x11, y11, ox11, oy11;
  logic        in_x, in_y;
  logic [9:0]  dx, dy;

  assign x11  = {1'b0, draw_x};
  assign y11  = {1'b0, draw_y};
  assign ox11 = {1'b0, org_x};
  assign oy11 = {1'b0, org_y};

  assign in_x = (x11 >= ox11) && (x11 < ox11 + 11'(SPR_W));
  assign in_y = (y11 >= oy11) && (y11 < oy11 + 11'(SPR_H));

  assign in_box = en && pix_valid && in_x && in_y;

  // Offsets are only meaningful inside the box, where both are below 20.
  assign dx = draw_x - org_x;
  assign dy = draw_y - org_y;

  assign addr = in_box ? 9'((dy * 10'(SPR_W)) + dx) : 9'd0;

endmodule

// File: rtl/ghost_sprite_renderer.sv
// Ghost sprite renderer: box test, sprite RAM read, transparency and fright recolour.
// Latency 3 cycles pixel-to-result, one pixel per cycle; no backpressure, never stalls.
// Ports: Clk/Reset_n, pix scan bundle (slave), live ghost state, RAM read port.
module ghost_sprite_renderer
  import sprite_pkg::rgb_t;
#(
  parameter int   FLASH_PERIOD = 8,
  parameter rgb_t TRANSPARENT  = sprite_pkg::TRANSPARENT,
  parameter rgb_t FRIGHT_RGB   = sprite_pkg::FRIGHT_RGB,
  parameter rgb_t FLASH_RGB    = sprite_pkg::FLASH_RGB
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  ghost_sprite_renderer_if.slave  pix,
  input  logic [9:0]              GhostX,
  input  logic [9:0]              GhostY,
  input  logic                    ghost_en,
  input  logic                    frightened,
  input  logic                    fright_ending,
  output logic [8:0]              read_address,
  input  rgb_t                    ram_data
);

  localparam int CW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  // Game state captured once per frame so the sprite never tears mid-scan.
  logic [9:0]    gx_l, gy_l;
  logic          en_l, fr_l, fe_l;

  logic [CW-1:0] flash_cnt;
  logic          flash_phase;

  logic          in_box;
  logic [8:0]    addr_c;

  logic          v1, h1;
  logic          v2, h2;

  logic          hit_c;
  rgb_t          rgb_c;

  logic          out_valid_q, ghost_hit_q;
  rgb_t          ghost_rgb_q;

  sprite_box_addr u_box (
    .draw_x    (pix.DrawX),
    .draw_y    (pix.DrawY),
    .org_x     (gx_l),
    .org_y     (gy_l),
    .en        (en_l),
    .pix_valid (pix.pix_valid),
    .in_box    (in_box),
    .addr      (addr_c)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gx_l <= '0;
      gy_l <= '0;
      en_l <= 1'b0;
      fr_l <= 1'b0;
      fe_l <= 1'b0;
    end else if (pix.frame_start) begin
      gx_l <= GhostX;
      gy_l <= GhostY;
      en_l <= ghost_en;
      fr_l <= frightened;
      fe_l <= fright_ending;
    end
  end

  // Counts frames while the latched ending flag is set; the phase flips
  // every FLASH_PERIOD frames. Uses the pre-update latch, so the frame that
  // first latches fright_ending starts a full half-period of solid blue.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (!fe_l) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (pix.frame_start) begin
      if (flash_cnt == CW'(FLASH_PERIOD - 1)) begin
        flash_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

  // Stage 1 registers the RAM address; stage 2 tracks the pixel while the
  // RAM's own output register holds its data, so ram_data lines up with h2.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      v1           <= 1'b0;
      h1           <= 1'b0;
      v2           <= 1'b0;
      h2           <= 1'b0;
    end else begin
      read_address <= addr_c;
      v1           <= pix.pix_valid;
      h1           <= in_box;
      v2           <= v1;
      h2           <= h1;
    end
  end

  always_comb begin
    hit_c = h2 && (ram_data != TRANSPARENT);
    rgb_c = '0;
    if (hit_c) begin
      if (!fr_l)            rgb_c = ram_data;
      else if (flash_phase) rgb_c = FLASH_RGB;
      else                  rgb_c = FRIGHT_RGB;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      ghost_hit_q <= 1'b0;
      ghost_rgb_q <= '0;
    end else begin
      out_valid_q <= v2;
      ghost_hit_q <= hit_c;
      ghost_rgb_q <= rgb_c;
    end
  end

  assign pix.out_valid = out_valid_q;
  assign pix.ghost_hit = ghost_hit_q;
  assign pix.ghost_rgb = ghost_rgb_q;

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Self-checking bench for ghost_sprite_renderer: directed cases plus random scan.
// A frame-level reference model predicts every output; directed literals pin it.
// No backpressure in the design; the bench drives one pixel per cycle.
module tb_ghost_sprite_renderer;
  import sprite_pkg::*;

  localparam int FP = 2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] GhostX = '0, GhostY = '0;
  logic       ghost_en = 1'b0, frightened = 1'b0, fright_ending = 1'b0;
  logic [8:0] read_address;
  rgb_t       ram_data;

  ghost_sprite_renderer_if pix_if ();

  ghost_sprite_renderer #(.FLASH_PERIOD(FP)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .pix           (pix_if.slave),
    .GhostX        (GhostX),
    .GhostY        (GhostY),
    .ghost_en      (ghost_en),
    .frightened    (frightened),
    .fright_ending (fright_ending),
    .read_address  (read_address),
    .ram_data      (ram_data)
  );

  always #5 Clk = ~Clk;

  // Sprite RAM stand-in with a one-cycle registered read.
  rgb_t mem [SPR_WORDS];
  always @(posedge Clk) ram_data <= (read_address < 9'(SPR_WORDS)) ? mem[read_address] : 24'hBAD000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit v; bit h; int a; } ent_t;

  int   m_gx, m_gy, m_k;
  bit   m_en, m_fr, m_fe;
  ent_t p0, p1;
  bit   e_v, e_h;
  rgb_t e_rgb;
  int   e_addr;

  function void m_clear();
    m_gx = 0; m_gy = 0; m_k = 0;
    m_en = 0; m_fr = 0; m_fe = 0;
    p0 = '{0, 0, 0}; p1 = '{0, 0, 0};
    e_v = 0; e_h = 0; e_rgb = '0; e_addr = 0;
  endfunction

  function void m_step();
    ent_t n;
    int   x, y;
    rgb_t d;
    bit   fs;
    x  = int'(pix_if.DrawX);
    y  = int'(pix_if.DrawY);
    fs = pix_if.frame_start;
    n.v = pix_if.pix_valid;
    n.h = n.v && m_en && x >= m_gx && x < m_gx + SPR_W && y >= m_gy && y < m_gy + SPR_H;
    n.a = n.h ? (y - m_gy) * SPR_W + (x - m_gx) : 0;
    // Result for the pixel accepted two edges ago, using current frame state.
    d     = mem[p1.a];
    e_v   = p1.v;
    e_h   = p1.h && (d != TRANSPARENT);
    e_rgb = !e_h ? 24'h0 : (!m_fr ? d : (((m_k / FP) % 2) == 1 ? FLASH_RGB : FRIGHT_RGB));
    e_addr = n.a;
    p1 = p0;
    p0 = n;
    // Frames counted while flashing was already latched; cleared otherwise.
    if (!m_fe) m_k = 0;
    else if (fs) m_k++;
    if (fs) begin
      m_gx = int'(GhostX); m_gy = int'(GhostY);
      m_en = ghost_en; m_fr = frightened; m_fe = fright_ending;
    end
  endfunction

  always @(posedge Clk) begin
    if (!Reset_n) m_clear();
    else m_step();
  end

  always @(negedge Reset_n) m_clear();

  always @(negedge Clk) begin
    chk("out_valid",    32'(pix_if.out_valid), 32'(e_v));
    chk("ghost_hit",    32'(pix_if.ghost_hit), 32'(e_h));
    chk("ghost_rgb",    32'(pix_if.ghost_rgb), 32'(e_rgb));
    chk("read_address", 32'(read_address),     32'(e_addr));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int x, input int y, input bit v, input bit fs);
    pix_if.DrawX       = 10'(x);
    pix_if.DrawY       = 10'(y);
    pix_if.pix_valid   = v;
    pix_if.frame_start = fs;
    @(posedge Clk);
    #2;
  endtask

  task automatic drain();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic set_ghost(input int gx, input int gy, input bit en, input bit fr, input bit fe);
    GhostX = 10'(gx); GhostY = 10'(gy);
    ghost_en = en; frightened = fr; fright_ending = fe;
  endtask

  initial begin
    rgb_t flash_exp [5];
    int   hits;
    int   gx, x, y;
    flash_exp[0] = 24'h2121DE; flash_exp[1] = 24'h2121DE;
    flash_exp[2] = 24'hFFFFFF; flash_exp[3] = 24'hFFFFFF;
    flash_exp[4] = 24'h2121DE;

    for (int i = 0; i < SPR_WORDS; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 24'h0 : (rgb_t'($urandom) | 24'h000001);
    for (int i = 0; i < SPR_W; i++) mem[i] = rgb_t'($urandom) | 24'h010000;
    mem[65]  = 24'hFF0000;
    mem[189] = 24'h00FF00;

    pix_if.DrawX = '0; pix_if.DrawY = '0;
    pix_if.pix_valid = 1'b0; pix_if.frame_start = 1'b0;

    // Reset state
    repeat (3) @(posedge Clk);
    #2;
    chk("rst_addr",  32'(read_address),     32'd0);
    chk("rst_valid", 32'(pix_if.out_valid), 32'd0);
    chk("rst_hit",   32'(pix_if.ghost_hit), 32'd0);
    chk("rst_rgb",   32'(pix_if.ghost_rgb), 32'd0);
    Reset_n = 1'b1;
    step(0, 0, 0, 0);

    // Single opaque pixel at (105,53) with ghost at (100,50)
    set_ghost(100, 50, 1, 0, 0);
    step(0, 0, 0, 1);
    step(105, 53, 1, 0);
    chk("t1_addr", 32'(read_address), 32'd65);
    drain();
    chk("t1_valid", 32'(pix_if.out_valid), 32'd1);
    chk("t1_hit",   32'(pix_if.ghost_hit), 32'd1);
    chk("t1_rgb",   32'(pix_if.ghost_rgb), 32'hFF0000);

    // Scan row 50 across the left and right box edges
    hits = 0;
    for (int xx = 99; xx <= 120; xx++) begin
      step(xx, 50, 1, 0);
      if (xx == 99)  chk("scan_addr_99",  32'(read_address), 32'd0);
      if (xx == 119) chk("scan_addr_119", 32'(read_address), 32'd19);
      if (xx == 120) chk("scan_addr_120", 32'(read_address), 32'd0);
      hits += int'(pix_if.ghost_hit);
    end
    step(0, 0, 0, 0); hits += int'(pix_if.ghost_hit);
    step(0, 0, 0, 0); hits += int'(pix_if.ghost_hit);
    chk("scan_hits", 32'(hits), 32'd20);

    // Transparent pixel inside the box
    mem[70] = 24'h000000;
    step(110, 53, 1, 0);
    chk("tr_addr", 32'(read_address), 32'd70);
    drain();
    chk("tr_valid", 32'(pix_if.out_valid), 32'd1);
    chk("tr_hit",   32'(pix_if.ghost_hit), 32'd0);
    chk("tr_rgb",   32'(pix_if.ghost_rgb), 32'd0);

    // Ghost hanging off the bottom-right corner
    set_ghost(630, 470, 1, 0, 0);
    step(0, 0, 0, 1);
    step(639, 479, 1, 0);
    chk("corner_addr", 32'(read_address), 32'd189);
    step(629, 479, 1, 0);
    chk("corner_left_addr", 32'(read_address), 32'd0);
    step(639, 469, 1, 0);
    chk("corner_up_addr", 32'(read_address), 32'd0);
    chk("corner_hit", 32'(pix_if.ghost_hit), 32'd1);
    chk("corner_rgb", 32'(pix_if.ghost_rgb), 32'h00FF00);
    for (int i = 0; i < 60; i++)
      step($urandom_range(600, 639), $urandom_range(440, 479), 1, 0);
    drain();

    // Frightened flashing, two frames per half-period
    set_ghost(100, 50, 1, 1, 1);
    for (int f = 0; f < 5; f++) begin
      step(0, 0, 0, 1);
      step(105, 53, 1, 0);
      drain();
      chk($sformatf("flash_f%0d", f), 32'(pix_if.ghost_rgb), 32'(flash_exp[f]));
    end
    fright_ending = 1'b0;
    step(0, 0, 0, 1);
    step(105, 53, 1, 0);
    drain();
    chk("fright_solid", 32'(pix_if.ghost_rgb), 32'h2121DE);

    // Mid-frame move and frame_start coincident with a pixel
    set_ghost(200, 100, 1, 0, 0);
    step(0, 0, 0, 1);
    GhostX = 10'd300;
    step(205, 100, 1, 0); drain();
    chk("mid_old_hit", 32'(pix_if.ghost_hit), 32'd1);
    step(305, 100, 1, 0); drain();
    chk("mid_new_miss", 32'(pix_if.ghost_hit), 32'd0);
    step(205, 100, 1, 1); drain();
    chk("fs_coincident_hit", 32'(pix_if.ghost_hit), 32'd1);
    step(305, 100, 1, 0); drain();
    chk("after_fs_hit", 32'(pix_if.ghost_hit), 32'd1);

    // Randomised scan with random frame pulses and live state changes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        set_ghost($urandom_range(0, 650), $urandom_range(0, 490), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        step(0, 0, $urandom_range(0, 1) == 1, 1);
      end else begin
        if ($urandom_range(0, 99) == 0) GhostX = 10'($urandom_range(0, 639));
        gx = int'(dut.gx_l);
        gx = 0;
        gx = m_gx;
        x = gx - 3 + int'($urandom_range(0, 25));
        y = m_gy - 3 + int'($urandom_range(0, 25));
        if ($urandom_range(0, 3) == 0) begin
          x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479));
        end
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        step(x, y, $urandom_range(0, 3) != 0, 0);
      end
    end
    drain();

    // Reset asserted mid-scan
    set_ghost(100, 50, 1, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(105 + i, 53, 1, 0);
    Reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(pix_if.out_valid), 32'd0);
    chk("arst_hit",   32'(pix_if.ghost_hit), 32'd0);
    step(105, 53, 1, 0);
    step(105, 53, 1, 0);
    Reset_n = 1'b1;
    step(0, 0, 0, 1);
    step(105, 53, 1, 0);
    chk("post_rst_addr", 32'(read_address), 32'd65);
    step(0, 0, 0, 0);
    chk("post_rst_valid_c2", 32'(pix_if.out_valid), 32'd0);
    step(0, 0, 0, 0);
    chk("post_rst_valid_c3", 32'(pix_if.out_valid), 32'd1);
    chk("post_rst_rgb",      32'(pix_if.ghost_rgb), 32'hFF0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ghost_sprite_renderer.md
Name: ghost_sprite_renderer

Overview:
- Downstream consumer of the per-ghost sprite RAM (20x20 pixels, 24-bit RGB, 400 words, one-cycle registered read).
- Per VGA pixel: decides whether the pixel falls inside the ghost's 20x20 box and drives the RAM read address.
- Aligns the returned RAM data with its pixel, applies transparency keying and frightened-mode recolouring (solid blue, or blue/white flashing), then hands a colour and hit flag to the colour mapper.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- TRANSPARENT, 24'h000000, RAM colour treated as see-through
- FRIGHT_RGB, 24'h2121DE, frightened body colour
- FLASH_RGB, 24'hFFFFFF, alternate colour while frightened is ending
- FLASH_PERIOD, 8, frames per flash half-period (>=1)

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- pix_valid  in  1  DrawX/DrawY is a visible pixel this cycle
- GhostX  in  10  ghost top-left column (live game state)
- GhostY  in  10  ghost top-left row (live game state)
- ghost_en  in  1  ghost drawn this frame
- frightened  in  1  frightened mode active
- fright_ending  in  1  frightened about to expire (flash)
- read_address  out  9  to sprite RAM read port
- ram_data  in  24  sprite RAM data_Out
- out_valid  out  1  pixel result valid, 3 cycles after pix_valid
- ghost_hit  out  1  opaque ghost pixel at this position
- ghost_rgb  out  24  colour when ghost_hit, else 0

Behaviour:
- Reset (async, Reset_n=0) clears:
  - read_address, out_valid, ghost_hit, ghost_rgb, latched position, pipeline valids and flash counter/phase to 0.
  - latched enable to 0.
- Position latch: GhostX/GhostY/ghost_en are sampled only on frame_start. A mid-frame position change takes effect next frame (no tearing).
- Stage 1 (edge after pix_valid):
  - in_box = en_l & pix_valid & DrawX>=GX_l & DrawX<GX_l+SPR_W & DrawY>=GY_l & DrawY<GY_l+SPR_H.
  - Compare in 11-bit arithmetic; no wrap.
  - read_address <= in_box ? (DrawY-GY_l)*SPR_W + (DrawX-GX_l) : 0. Range 0..399.
  - Register v1 = pix_valid and h1 = in_box.
- Stage 2: RAM returns ram_data for the stage-1 address. Register v2, h2, and d2 = ram_data.
- Stage 3 (outputs):
  - out_valid <= v2.
  - ghost_hit <= h2 & (d2 != TRANSPARENT).
  - ghost_rgb <= !hit ? 0 : (!frightened_l ? d2 : (flash_phase ? FLASH_RGB : FRIGHT_RGB)).
- Latency is exactly 3 cycles, fully pipelined; one pixel accepted per cycle with no stalls.
- Frightened inputs are also latched on frame_start.
- Flash counter:
  - Increments on frame_start while fright_ending_l=1.
  - On reaching FLASH_PERIOD-1 it wraps to 0 and toggles flash_phase.
  - When fright_ending_l=0, counter and flash_phase are held at 0.
- Clipping: a ghost partly off the right or bottom edge is drawn only where DrawX/DrawY are legal; no address wrap.
- GhostX=0 or GhostY=0 is legal.
- Bubbles: pix_valid=0 propagates as out_valid=0 with ghost_hit=0.
- frame_start coincident with pix_valid: pixel uses the previous latched position; the new latch takes effect next cycle.
- Reset mid-pipeline: in-flight pixels are discarded. The first out_valid is 3 cycles after the first pix_valid following release.
- This block never drives the RAM write port.

Decomposition:
- Shared package sprite_pkg: SPR_W/SPR_H constants, rgb_t (24-bit), screen width/height constants, colour constants (TRANSPARENT, FRIGHT_RGB, FLASH_RGB). Reused by the pacman and other ghost renderers.
- One natural sub-module: sprite_box_addr. Combinational in-box test plus address computation, instanced once here and shared by all sprite renderers.

Test Plan:
- Reset, latch GhostX=100/GhostY=50, enable.
  - Drive DrawX=105, DrawY=53 with RAM model returning 24'hFF0000 at address 65.
  - Expect read_address=65 one cycle later; out_valid=1, ghost_hit=1, ghost_rgb=FF0000 at cycle 3.
- Same ghost, scan row 50, DrawX 99..120.
  - Expect hits only for DrawX 100..119; addresses 0..19.
  - DrawX=99 and 120 give hit=0 and read_address=0.
- RAM returns 000000 inside the box → ghost_hit=0, ghost_rgb=0, out_valid=1.
- GhostX=630, GhostY=470: pixel (639,479) hits with address 9*20+9=189; no hit anywhere else out of range.
- frightened=1, fright_ending=1, FLASH_PERIOD=2, opaque pixel.
  - Expect colour 2121DE for frames 0-1, FFFFFF for frames 2-3, then 2121DE again.
  - Drop fright_ending → 2121DE.
- Change GhostX mid-frame → hits follow the old position until after the next frame_start.
  - Assert Reset_n=0 mid-scan → out_valid drops to 0 immediately and asynchronously.
